karatsuba_sequencer: RTL and testbench

KARATSUBA_SEQUENCER -- requirements
Module: karatsuba_sequencer

---
 rtl/karatsuba_pkg.sv | 31 +++
 rtl/karatsuba_sequencer_clmul.sv | 49 ++++
 rtl/karatsuba_sequencer.sv | 125 ++++++++++++
 tb/tb_karatsuba_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/karatsuba_pkg.sv
// Shared constants and FSM state encoding for the Karatsuba GF(2) multiplier.
// States are plain constants so legacy tools and waveform viewers see stable codes.
package karatsuba_pkg;

    localparam int DEFAULT_WIDTH = 224;
    localparam int DEFAULT_HALF  = DEFAULT_WIDTH / 2;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_MUL_HI  = 3'd1;
    localparam state_t ST_MUL_LO  = 3'd2;
    localparam state_t ST_MUL_MID = 3'd3;
    localparam state_t ST_COMBINE = 3'd4;
    localparam state_t ST_OUT     = 3'd5;

    function automatic logic is_mul_state(input state_t s);
        return (s == ST_MUL_HI) || (s == ST_MUL_LO) || (s == ST_MUL_MID);
    endfunction

    // Sub-product order: high halves, low halves, then the cross term.
    function automatic state_t next_mul_state(input state_t s);
        case (s)
            ST_MUL_HI:  return ST_MUL_LO;
            ST_MUL_LO:  return ST_MUL_MID;
            ST_MUL_MID: return ST_COMBINE;
            default:    return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/karatsuba_sequencer_clmul.sv
// Bit-serial HALF x HALF carry-less multiplier, one multiplier bit per step, LSB first.
// A step with start high restarts the product from the presented operands.
module clmul_bitserial
    import karatsuba_pkg::*;
#(
    parameter int HALF = DEFAULT_HALF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                step,
    input  logic [HALF-1:0]     x,
    input  logic [HALF-1:0]     y,
    output logic [2*HALF-1:0]   p
);

    logic [2*HALF-1:0] acc;
    logic [2*HALF-1:0] xs;
    logic [HALF-1:0]   ys;

    logic [2*HALF-1:0] cur_x;
    logic [HALF-1:0]   cur_y;
    logic [2*HALF-1:0] base;
    logic [2*HALF-1:0] partial;

    // NOTE: every signal assigned in always_comb gets a value on all paths, otherwise a latch is inferred.
    always_comb begin
        cur_x   = start ? (2*HALF)'(x) : xs;
        cur_y   = start ? y : ys;
        base    = start ? '0 : acc;
        partial = cur_y[0] ? cur_x : '0;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc <= '0;
            xs  <= '0;
            ys  <= '0;
        end else if (step) begin
            acc <= base ^ partial;
            xs  <= cur_x << 1;
            ys  <= cur_y >> 1;
        end
    end

    assign p = acc;

endmodule

// File: rtl/karatsuba_sequencer.sv
// Two-way Karatsuba carry-less multiplier: three sub-products time-share one
// bit-serial multiplier, then a single combine cycle assembles the product.
module karatsuba_sequencer
    import karatsuba_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int HALF  = WIDTH / 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   c,
    output logic                 busy
);

    localparam int              CW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0]   LAST = CW'(HALF - 1);

    state_t              state;
    state_t              state_nxt;
    logic [CW-1:0]       cnt;
    logic [WIDTH-1:0]    a_reg;
    logic [WIDTH-1:0]    b_reg;
    logic [2*HALF-1:0]   h_acc;
    logic [2*HALF-1:0]   l_acc;
    logic [2*HALF-1:0]   p;

    logic [HALF-1:0]     mul_x;
    logic [HALF-1:0]     mul_y;
    logic                mul_step;
    logic                mul_start;
    logic                last_bit;
    logic                accept;
    logic [2*HALF-1:0]   mid;
    logic [2*WIDTH-1:0]  c_nxt;

    // in_ready is gated by rst so nothing is offered while reset is asserted.
    assign in_ready  = rst && (state == ST_IDLE);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == ST_OUT);
    assign busy      = (state != ST_IDLE);

    assign mul_step  = is_mul_state(state);
    assign mul_start = mul_step && (cnt == '0);
    assign last_bit  = mul_step && (cnt == LAST);

    always_comb begin
        mul_x = a_reg[HALF-1:0] ^ a_reg[WIDTH-1:HALF];
        mul_y = b_reg[HALF-1:0] ^ b_reg[WIDTH-1:HALF];
        case (state)
            ST_MUL_HI: begin
                mul_x = a_reg[WIDTH-1:HALF];
                mul_y = b_reg[WIDTH-1:HALF];
            end
            ST_MUL_LO: begin
                mul_x = a_reg[HALF-1:0];
                mul_y = b_reg[HALF-1:0];
            end
            default: ;
        endcase
    end

    clmul_bitserial #(
        .HALF (HALF)
    ) u_clmul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .step  (mul_step),
        .x     (mul_x),
        .y     (mul_y),
        .p     (p)
    );

    // During COMBINE the multiplier output is the finished cross product M.
    always_comb begin
        mid   = p ^ h_acc ^ l_acc;
        c_nxt = ((2*WIDTH)'(h_acc) << WIDTH)
              ^ ((2*WIDTH)'(mid) << HALF)
              ^ (2*WIDTH)'(l_acc);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (accept) state_nxt = ST_MUL_HI;
            ST_MUL_HI,
            ST_MUL_LO,
            ST_MUL_MID: if (last_bit) state_nxt = next_mul_state(state);
            ST_COMBINE: state_nxt = ST_OUT;
            ST_OUT:     if (out_ready) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sub-product accumulators and c are explicitly cleared so an aborted operation leaves no residue.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            a_reg <= '0;
            b_reg <= '0;
            h_acc <= '0;
            l_acc <= '0;
            c     <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_reg <= a;
                b_reg <= b;
            end
            if (mul_step) cnt <= last_bit ? '0 : cnt + 1'b1;
            // The previous sub-product is still in the multiplier on the first cycle of the next one.
            if (state == ST_MUL_LO && cnt == '0) h_acc <= p;
            if (state == ST_MUL_MID && cnt == '0) l_acc <= p;
            if (state == ST_COMBINE) c <= c_nxt;
        end
    end

endmodule

// File: tb/tb_karatsuba_sequencer.sv
// Directed and model-checked bench for karatsuba_sequencer at WIDTH=224.
module tb_karatsuba_sequencer;

    localparam int W   = 224;
    localparam int H   = W / 2;
    localparam int PW  = 2 * W;
    localparam int LAT = 3 * H + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] c;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    karatsuba_sequencer #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Schoolbook shift-and-XOR reference, independent of the Karatsuba split.
    function automatic logic [PW-1:0] clmul_ref(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [PW-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++)
            if (y[i]) r = r ^ (PW'(x) << i);
        return r;
    endfunction

    function automatic logic [W-1:0] rand_op();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // One full operation: handshake, scramble inputs, wait for out_valid,
    // optionally stall the consumer, then take the result.
    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                          input int stall, input bit noise, output logic [PW-1:0] res);
        int n;
        @(negedge clk);
        check("in_ready_idle", PW'(in_ready), PW'(1));
        a = xa;
        b = xb;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = rand_op();
        b = rand_op();
        // n is the index of the next rising edge after the handshake edge.
        n = 0;
        while (n < LAT + 20) begin
            @(negedge clk);
            n++;
            if (out_valid) break;
            if (noise) begin
                in_valid  = 1'($urandom_range(0, 1));
                out_ready = 1'($urandom_range(0, 1));
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("latency", PW'(n), PW'(LAT));
        res = c;
        for (int i = 0; i < stall; i++) begin
            if (noise) in_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("hold_c", c, res);
            check("hold_valid", PW'(out_valid), PW'(1));
            check("hold_in_ready", PW'(in_ready), PW'(0));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("released_valid", PW'(out_valid), PW'(0));
        check("released_busy", PW'(busy), PW'(0));
    endtask

    initial begin
        logic [W-1:0]  xa;
        logic [W-1:0]  xb;
        logic [PW-1:0] exp;
        logic [PW-1:0] res;
        logic          seen;

        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", PW'(in_ready), PW'(0));
        check("rst_out_valid", PW'(out_valid), PW'(0));
        check("rst_busy", PW'(busy), PW'(0));
        check("rst_c", c, '0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("in_ready_after_rst", PW'(in_ready), PW'(1));

        run_op(W'(1), W'(1), 0, 1'b0, res);
        check("one_x_one", res, PW'(1));

        xa = '1;
        exp = {W{2'b01}};
        run_op(xa, xa, 0, 1'b0, res);
        check("all_ones_sq", res, exp);

        xa = W'(1) << 223;
        exp = PW'(1) << 446;
        run_op(xa, xa, 0, 1'b0, res);
        check("top_bit_sq", res, exp);

        xb = rand_op();
        run_op('0, xb, 0, 1'b0, res);
        check("zero_a", res, '0);

        run_op(W'(5), W'(3), 0, 1'b0, res);
        check("five_x_three", res, PW'(15));

        // (x^112 + 1)^2 = x^224 + 1 exercises the cross term across the halves.
        xa = (W'(1) << 112) | W'(1);
        exp = (PW'(1) << 224) | PW'(1);
        run_op(xa, xa, 0, 1'b0, res);
        check("half_split_sq", res, exp);

        run_op(W'(1) << 111, W'(1) << 112, 0, 1'b0, res);
        check("lo_x_hi", res, PW'(1) << 223);

        xa = rand_op();
        xb = rand_op();
        run_op(xa, xb, 10, 1'b1, res);
        check("stalled_random", res, clmul_ref(xa, xb));

        // Abort in MUL_MID at bit 50.
        @(negedge clk);
        a = rand_op();
        b = rand_op();
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2 * H + 50) @(posedge clk);
        #1;
        check("busy_before_abort", PW'(busy), PW'(1));
        rst = 1'b0;
        #1;
        check("abort_in_ready_low", PW'(in_ready), PW'(0));
        @(posedge clk);
        #1;
        check("abort_busy", PW'(busy), PW'(0));
        check("abort_out_valid", PW'(out_valid), PW'(0));
        check("abort_c", c, '0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_in_ready_back", PW'(in_ready), PW'(1));
        seen = 1'b0;
        repeat (LAT + 20) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        check("abort_no_out_valid", PW'(seen), PW'(0));

        run_op(W'(3), W'(3), 0, 1'b0, res);
        check("three_x_three", res, PW'(5));

        for (int i = 0; i < 15; i++) begin
            xa = rand_op();
            xb = rand_op();
            run_op(xa, xb, $urandom_range(0, 3), 1'b1, res);
            check("random_op", res, clmul_ref(xa, xb));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
